// File: rtl/segre_pkg.sv
// Shared types and constants for the memory stage and its data array.
// Includes load extraction and store byte-lane helpers.
package segre_pkg;

    localparam int WORD_SIZE          = 32;
    localparam int REG_SIZE           = 5;
    localparam int DCACHE_NUM_LINES   = 4;
    localparam int DCACHE_LANE_SIZE   = 128;
    localparam int DCACHE_INDEX_SIZE  = $clog2(DCACHE_NUM_LINES);
    localparam int DCACHE_BYTES       = DCACHE_LANE_SIZE / 8;
    localparam int DCACHE_OFFSET_SIZE = $clog2(DCACHE_BYTES);

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memop_data_type_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_WAIT = 2'd1,
        FILL      = 2'd2
    } mem_fsm_state_e;

    typedef struct packed {
        logic [WORD_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] st_data;
        logic                 we;
        logic [REG_SIZE-1:0]  waddr;
        logic                 rd;
        logic                 wr;
        logic                 sext;
        memop_data_type_e     mtype;
        logic                 tkbr;
        logic [WORD_SIZE-1:0] new_pc;
    } mem_op_t;

    // Offset bits below the operand size are dropped here.
    function automatic logic [WORD_SIZE-1:0] load_extract(
        input logic [DCACHE_LANE_SIZE-1:0]   line,
        input logic [DCACHE_OFFSET_SIZE-1:0] off,
        input memop_data_type_e              mtype,
        input logic                          sext
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        b = line[{off, 3'b000} +: 8];
        h = line[{off[3:1], 4'b0000} +: 16];
        w = line[{off[3:2], 5'b00000} +: 32];
        case (mtype)
            BYTE:    load_extract = {{24{sext & b[7]}}, b};
            HALF:    load_extract = {{16{sext & h[15]}}, h};
            default: load_extract = w;
        endcase
    endfunction

    function automatic logic [DCACHE_BYTES-1:0] store_be(
        input logic [DCACHE_OFFSET_SIZE-1:0] off,
        input memop_data_type_e              mtype
    );
        case (mtype)
            BYTE:    store_be = 16'h0001 << off;
            HALF:    store_be = 16'h0003 << {off[3:1], 1'b0};
            default: store_be = 16'h000F << {off[3:2], 2'b00};
        endcase
    endfunction

    function automatic logic [DCACHE_LANE_SIZE-1:0] store_wdata(
        input logic [WORD_SIZE-1:0] st,
        input memop_data_type_e     mtype
    );
        case (mtype)
            BYTE:    store_wdata = {16{st[7:0]}};
            HALF:    store_wdata = {8{st[15:0]}};
            default: store_wdata = {4{st}};
        endcase
    endfunction

endpackage

// File: rtl/segre_mem_stage_if.sv
// Bundle between tag-lookup, MMU, memory stage and write-back.
// master drives the stage inputs, slave is the memory stage.
interface segre_mem_stage_if;
    import segre_pkg::*;

    logic [WORD_SIZE-1:0]        alu_res_i;
    logic [WORD_SIZE-1:0]        rf_st_data_i;
    logic                        rf_we_i;
    logic [REG_SIZE-1:0]         rf_waddr_i;
    logic                        memop_rd_i;
    logic                        memop_wr_i;
    logic                        memop_sign_ext_i;
    memop_data_type_e            memop_type_i;
    logic                        tkbr_i;
    logic [WORD_SIZE-1:0]        new_pc_i;
    logic                        mmu_miss_i;
    logic                        mmu_data_rdy_i;
    logic [DCACHE_LANE_SIZE-1:0] mmu_data_i;

    logic                        rf_we_o;
    logic [REG_SIZE-1:0]         rf_waddr_o;
    logic [WORD_SIZE-1:0]        rf_data_o;
    logic                        tkbr_o;
    logic [WORD_SIZE-1:0]        new_pc_o;
    logic                        pipeline_hazard_o;

    modport master (
        output alu_res_i, rf_st_data_i, rf_we_i, rf_waddr_i,
        output memop_rd_i, memop_wr_i, memop_sign_ext_i, memop_type_i,
        output tkbr_i, new_pc_i, mmu_miss_i, mmu_data_rdy_i, mmu_data_i,
        input  rf_we_o, rf_waddr_o, rf_data_o, tkbr_o, new_pc_o,
        input  pipeline_hazard_o
    );

    modport slave (
        input  alu_res_i, rf_st_data_i, rf_we_i, rf_waddr_i,
        input  memop_rd_i, memop_wr_i, memop_sign_ext_i, memop_type_i,
        input  tkbr_i, new_pc_i, mmu_miss_i, mmu_data_rdy_i, mmu_data_i,
        output rf_we_o, rf_waddr_o, rf_data_o, tkbr_o, new_pc_o,
        output pipeline_hazard_o
    );

endinterface

// File: rtl/segre_dcache_data.sv
// Data cache line storage with per-byte write enables.
// Asynchronous read; contents are never reset.
module segre_dcache_data
    import segre_pkg::*;
(
    input  logic                         i_clk,
    input  logic [DCACHE_INDEX_SIZE-1:0] i_index,
    input  logic [DCACHE_BYTES-1:0]      i_be,
    input  logic [DCACHE_LANE_SIZE-1:0]  i_wdata,
    output logic [DCACHE_LANE_SIZE-1:0]  o_rdata
);

    logic [DCACHE_LANE_SIZE-1:0] r_mem [DCACHE_NUM_LINES];

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DCACHE_BYTES; i++) begin
            if (i_be[i]) begin
                r_mem[i_index][i*8 +: 8] <= i_wdata[i*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_index];

endmodule

// File: rtl/segre_mem_stage.sv
// Memory stage: loads/stores against the data array, with a
// blocking miss sequence that waits for an MMU line fill.
module segre_mem_stage
    import segre_pkg::*;
(
    input logic               clk_i,
    input logic               rst_i,
    segre_mem_stage_if.slave  bus
);

    mem_fsm_state_e                r_state;
    mem_op_t                       r_op;
    logic                          r_rf_we;
    logic [REG_SIZE-1:0]           r_rf_waddr;
    logic [WORD_SIZE-1:0]          r_rf_data;
    logic                          r_tkbr;
    logic [WORD_SIZE-1:0]          r_new_pc;
    logic                          r_hazard;

    mem_op_t                       w_in;
    mem_op_t                       w_op;
    logic                          w_miss;
    logic                          w_fill;
    logic                          w_exec;
    logic [DCACHE_INDEX_SIZE-1:0]  w_idx;
    logic [DCACHE_OFFSET_SIZE-1:0] w_off;
    logic [DCACHE_BYTES-1:0]       w_be;
    logic [DCACHE_LANE_SIZE-1:0]   w_wdata;
    logic [DCACHE_LANE_SIZE-1:0]   w_rdata;
    logic [WORD_SIZE-1:0]          w_load;

    assign w_in.addr    = bus.alu_res_i;
    assign w_in.st_data = bus.rf_st_data_i;
    assign w_in.we      = bus.rf_we_i;
    assign w_in.waddr   = bus.rf_waddr_i;
    assign w_in.rd      = bus.memop_rd_i;
    assign w_in.wr      = bus.memop_wr_i;
    assign w_in.sext    = bus.memop_sign_ext_i;
    assign w_in.mtype   = bus.memop_type_i;
    assign w_in.tkbr    = bus.tkbr_i;
    assign w_in.new_pc  = bus.new_pc_i;

    // Outside IDLE the stalled inputs are ignored in favour of the latched op.
    assign w_op   = (r_state == IDLE) ? w_in : r_op;
    assign w_idx  = w_op.addr[5:4];
    assign w_off  = w_op.addr[3:0];
    assign w_miss = (r_state == IDLE) && bus.mmu_miss_i
                    && (w_in.rd || w_in.wr);
    assign w_fill = (r_state == MISS_WAIT) && bus.mmu_data_rdy_i;
    assign w_exec = ((r_state == IDLE) && !w_miss) || (r_state == FILL);

    always_comb begin
        w_be    = '0;
        w_wdata = store_wdata(w_op.st_data, w_op.mtype);
        if (!rst_i) begin
            if (w_fill) begin
                w_be    = '1;
                w_wdata = bus.mmu_data_i;
            end else if (w_exec && w_op.wr) begin
                w_be = store_be(w_off, w_op.mtype);
            end
        end
    end

    segre_dcache_data u_data (
        .i_clk   (clk_i),
        .i_index (w_idx),
        .i_be    (w_be),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    assign w_load = load_extract(w_rdata, w_off, w_op.mtype, w_op.sext);

    always_ff @(posedge clk_i) begin
        if (!rst_i && w_miss) begin
            r_op <= w_in;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_data  <= '0;
            r_tkbr     <= 1'b0;
            r_new_pc   <= '0;
            r_hazard   <= 1'b0;
        end else begin
            if (w_exec) begin
                r_rf_we    <= w_op.we & ~w_op.wr;
                r_rf_waddr <= w_op.waddr;
                r_rf_data  <= w_op.rd ? w_load : w_op.addr;
                r_tkbr     <= w_op.tkbr;
                r_new_pc   <= w_op.new_pc;
                r_hazard   <= 1'b0;
            end else begin
                r_rf_we  <= 1'b0;
                r_tkbr   <= 1'b0;
                r_hazard <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_miss) r_state <= MISS_WAIT;
                end
                MISS_WAIT: begin
                    if (w_fill) r_state <= FILL;
                end
                FILL: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rf_we_o           = r_rf_we;
    assign bus.rf_waddr_o        = r_rf_waddr;
    assign bus.rf_data_o         = r_rf_data;
    assign bus.tkbr_o            = r_tkbr;
    assign bus.new_pc_o          = r_new_pc;
    assign bus.pipeline_hazard_o = r_hazard;

endmodule

// File: tb/tb_segre_mem_stage.sv
// Directed bench for segre_mem_stage: miss fill, loads, stores,
// branch pass-through and reset during a pending miss.
module tb_segre_mem_stage;
    import segre_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] LINE1 =
        128'h00112233_44556677_8899AABB_CCDDEEFF;

    segre_mem_stage_if bus ();

    segre_mem_stage dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus.alu_res_i        = '0;
        bus.rf_st_data_i     = '0;
        bus.rf_we_i          = 1'b0;
        bus.rf_waddr_i       = '0;
        bus.memop_rd_i       = 1'b0;
        bus.memop_wr_i       = 1'b0;
        bus.memop_sign_ext_i = 1'b0;
        bus.memop_type_i     = WORD;
        bus.tkbr_i           = 1'b0;
        bus.new_pc_i         = '0;
        bus.mmu_miss_i       = 1'b0;
        bus.mmu_data_rdy_i   = 1'b0;
        bus.mmu_data_i       = '0;
    endtask

    task automatic load(input logic [31:0] a, input logic [4:0] rd,
                        input memop_data_type_e t, input logic sx,
                        input logic miss);
        idle_in();
        bus.alu_res_i        = a;
        bus.rf_we_i          = 1'b1;
        bus.rf_waddr_i       = rd;
        bus.memop_rd_i       = 1'b1;
        bus.memop_sign_ext_i = sx;
        bus.memop_type_i     = t;
        bus.mmu_miss_i       = miss;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input memop_data_type_e t);
        idle_in();
        bus.alu_res_i    = a;
        bus.rf_st_data_i = d;
        bus.memop_wr_i   = 1'b1;
        bus.memop_type_i = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        tick();
        tick();
        chk("rst_we", 32'(bus.rf_we_o), 32'd0);
        chk("rst_tkbr", 32'(bus.tkbr_o), 32'd0);
        chk("rst_hz", 32'(bus.pipeline_hazard_o), 32'd0);
        chk("rst_waddr", 32'(bus.rf_waddr_o), 32'd0);
        chk("rst_data", bus.rf_data_o, 32'd0);
        chk("rst_pc", bus.new_pc_o, 32'd0);
        rst = 1'b0;

        // LW miss on line 1, fill arrives 5 cycles after issue
        load(32'h10, 5'd5, WORD, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("miss_hz", 32'(bus.pipeline_hazard_o), 32'd1);
            chk("miss_we", 32'(bus.rf_we_o), 32'd0);
        end
        bus.mmu_data_rdy_i = 1'b1;
        bus.mmu_data_i     = LINE1;
        tick();
        chk("fill_hz", 32'(bus.pipeline_hazard_o), 32'd1);
        chk("fill_we", 32'(bus.rf_we_o), 32'd0);
        bus.mmu_data_rdy_i = 1'b0;
        bus.mmu_miss_i     = 1'b0;
        tick();
        chk("done_hz", 32'(bus.pipeline_hazard_o), 32'd0);
        chk("done_we", 32'(bus.rf_we_o), 32'd1);
        chk("done_waddr", 32'(bus.rf_waddr_o), 32'd5);
        chk("done_data", bus.rf_data_o, 32'hCCDDEEFF);

        load(32'h1F, 5'd6, BYTE, 1'b1, 1'b0);
        tick();
        chk("lb_1f", bus.rf_data_o, 32'h00000000);
        chk("lb_waddr", 32'(bus.rf_waddr_o), 32'd6);
        load(32'h10, 5'd6, BYTE, 1'b1, 1'b0);
        tick();
        chk("lb_10", bus.rf_data_o, 32'hFFFFFFFF);
        load(32'h12, 5'd7, HALF, 1'b0, 1'b0);
        tick();
        chk("lhu_12", bus.rf_data_o, 32'h0000CCDD);
        load(32'h14, 5'd8, WORD, 1'b0, 1'b0);
        tick();
        chk("lw_14", bus.rf_data_o, 32'h8899AABB);
        chk("lw_we", 32'(bus.rf_we_o), 32'd1);

        store(32'h11, 32'h123456A5, BYTE);
        tick();
        chk("sb_we", 32'(bus.rf_we_o), 32'd0);
        load(32'h10, 5'd9, WORD, 1'b0, 1'b0);
        tick();
        chk("sb_lw10", bus.rf_data_o, 32'hCCDDA5FF);
        load(32'h14, 5'd9, WORD, 1'b0, 1'b0);
        tick();
        chk("sb_lw14", bus.rf_data_o, 32'h8899AABB);
        load(32'h18, 5'd9, WORD, 1'b0, 1'b0);
        tick();
        chk("sb_lw18", bus.rf_data_o, 32'h44556677);

        store(32'h1E, 32'h0000BEEF, HALF);
        tick();
        load(32'h1C, 5'd10, WORD, 1'b0, 1'b0);
        tick();
        chk("sh_lw1c", bus.rf_data_o, 32'hBEEF2233);
        load(32'h1E, 5'd10, HALF, 1'b1, 1'b0);
        tick();
        chk("lh_1e", bus.rf_data_o, 32'hFFFFBEEF);

        idle_in();
        bus.alu_res_i  = 32'h12345678;
        bus.rf_we_i    = 1'b1;
        bus.rf_waddr_i = 5'd11;
        tick();
        chk("alu_data", bus.rf_data_o, 32'h12345678);
        chk("alu_we", 32'(bus.rf_we_o), 32'd1);

        // Branch with a stray miss flag still passes straight through
        idle_in();
        bus.tkbr_i     = 1'b1;
        bus.new_pc_i   = 32'h400;
        bus.mmu_miss_i = 1'b1;
        tick();
        chk("br_tkbr", 32'(bus.tkbr_o), 32'd1);
        chk("br_pc", bus.new_pc_o, 32'h400);
        chk("br_hz", 32'(bus.pipeline_hazard_o), 32'd0);

        idle_in();
        bus.alu_res_i      = 32'h10;
        bus.mmu_data_rdy_i = 1'b1;
        bus.mmu_data_i     = {4{32'h55555555}};
        tick();
        chk("rdy_idle_hz", 32'(bus.pipeline_hazard_o), 32'd0);
        chk("rdy_idle_tkbr", 32'(bus.tkbr_o), 32'd0);
        chk("rdy_idle_data", bus.rf_data_o, 32'h10);
        load(32'h10, 5'd12, WORD, 1'b0, 1'b0);
        tick();
        chk("rdy_idle_lw", bus.rf_data_o, 32'hCCDDA5FF);
        chk("rdy_idle_hz2", 32'(bus.pipeline_hazard_o), 32'd0);

        // Reset while waiting, with the fill arriving on the reset edge
        load(32'h10, 5'd13, WORD, 1'b0, 1'b1);
        tick();
        chk("rm_hz0", 32'(bus.pipeline_hazard_o), 32'd1);
        tick();
        chk("rm_hz1", 32'(bus.pipeline_hazard_o), 32'd1);
        rst                = 1'b1;
        bus.mmu_data_rdy_i = 1'b1;
        bus.mmu_data_i     = {4{32'h55555555}};
        tick();
        chk("rm_we", 32'(bus.rf_we_o), 32'd0);
        chk("rm_hz", 32'(bus.pipeline_hazard_o), 32'd0);
        chk("rm_data", bus.rf_data_o, 32'd0);
        chk("rm_waddr", 32'(bus.rf_waddr_o), 32'd0);
        chk("rm_pc", bus.new_pc_o, 32'd0);
        chk("rm_tkbr", 32'(bus.tkbr_o), 32'd0);
        rst = 1'b0;
        idle_in();
        bus.mmu_data_rdy_i = 1'b1;
        bus.mmu_data_i     = {4{32'h55555555}};
        tick();
        chk("rm_rdy_hz", 32'(bus.pipeline_hazard_o), 32'd0);
        chk("rm_rdy_we", 32'(bus.rf_we_o), 32'd0);
        load(32'h10, 5'd14, WORD, 1'b0, 1'b0);
        tick();
        chk("rm_lw10", bus.rf_data_o, 32'hCCDDA5FF);
        load(32'h1C, 5'd14, WORD, 1'b0, 1'b0);
        tick();
        chk("rm_lw1c", bus.rf_data_o, 32'hBEEF2233);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
